// File: rtl/gv_pkg.sv
// -----------------------------------------------------------------------------
// gv_pkg
// Shared types and constants for the note playback slice.
//   gv_state_e    : playback FSM state encoding (IDLE/COUNTDOWN/PLAY/DONE)
//   SONG_LEN      : steps per lane
//   LANES         : number of note lanes
//   WINDOW        : look-ahead window width
//   window_slice(): extracts the look-ahead window starting at a beat
// -----------------------------------------------------------------------------
package gv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COUNTDOWN = 2'd1,
        ST_PLAY      = 2'd2,
        ST_DONE      = 2'd3
    } gv_state_e;

    localparam int unsigned SONG_LEN = 32;
    localparam int unsigned LANES    = 2;
    localparam int unsigned WINDOW   = 8;

    // Shifting right by the beat index zero-fills, so positions past the
    // last step read as 0 without an explicit bound check.
    function automatic logic [WINDOW-1:0] window_slice(
        input logic [SONG_LEN-1:0] lane,
        input logic [4:0]          idx,
        input logic                en
    );
        logic [SONG_LEN-1:0] shifted;
        shifted = lane >> idx;
        return en ? shifted[WINDOW-1:0] : '0;
    endfunction

endpackage

// File: rtl/beat_timer.sv
// -----------------------------------------------------------------------------
// beat_timer
// Free-running beat divider. Counts clk cycles while run is high and asserts
// tick for one cycle every BEAT_DIV cycles; clear forces the count to 0.
// Ports:
//   clk   : system clock
//   nrst  : asynchronous active-low reset
//   run   : count enable
//   clear : synchronous count clear (priority over run)
//   tick  : high on the last cycle of each beat (count == BEAT_DIV-1)
// -----------------------------------------------------------------------------
module beat_timer #(
    parameter int unsigned BEAT_DIV = 100000
) (
    input  logic clk,
    input  logic nrst,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int unsigned   CW   = $clog2(BEAT_DIV);
    localparam logic [CW-1:0] LAST = CW'(BEAT_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = run && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/note_player.sv
// -----------------------------------------------------------------------------
// note_player
// Snapshots two 32-step note lanes on start, counts down, then plays one beat
// per BEAT_DIV cycles, scoring player hits and driving an 8-beat look-ahead.
// Optional feature macro: GV_STREAK_EN (adds streak counter, bonus scoring
// and the streak port).
// Ports:
//   clk, nrst          : clock, asynchronous active-low reset
//   start              : single-cycle start pulse (accepted in IDLE/DONE)
//   note1, note2       : lane patterns, bit i = note at beat i
//   hit                : single-cycle presses, bit0 lane 1, bit1 lane 2
//   window1, window2   : look-ahead, bit0 = current beat
//   beat_idx           : current beat 0..31
//   score              : saturating hit count
//   miss_cnt           : saturating miss count (max 63)
//   state              : FSM state encoding
//   done               : high while in DONE
//   streak             : consecutive-hit count (GV_STREAK_EN only)
// -----------------------------------------------------------------------------
module note_player
    import gv_pkg::*;
#(
    parameter int unsigned BEAT_DIV        = 100000,
    parameter int unsigned COUNTDOWN_BEATS = 4,
    parameter int unsigned SCORE_W         = 8
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                start,
    input  logic [SONG_LEN-1:0] note1,
    input  logic [SONG_LEN-1:0] note2,
    input  logic [LANES-1:0]    hit,
    output logic [WINDOW-1:0]   window1,
    output logic [WINDOW-1:0]   window2,
    output logic [4:0]          beat_idx,
    output logic [SCORE_W-1:0]  score,
    output logic [5:0]          miss_cnt,
    output logic [1:0]          state,
    output logic                done
`ifdef GV_STREAK_EN
    ,
    output logic [3:0]          streak
`endif
);

    localparam int unsigned    CDW     = $clog2(COUNTDOWN_BEATS + 1);
    localparam logic [CDW-1:0] CD_LAST = CDW'(COUNTDOWN_BEATS - 1);

    gv_state_e           state_q, state_d;
    logic [4:0]          beat_q, beat_d;
    logic [CDW-1:0]      cd_q, cd_d;
    logic [SONG_LEN-1:0] sh1_q, sh1_d, sh2_q, sh2_d;
    logic [LANES-1:0]    cons_q, cons_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [5:0]          miss_q, miss_d;
    logic [WINDOW-1:0]   win1_q, win1_d, win2_q, win2_d;
    logic                done_q, done_d;

    logic tick, run, accept, in_play;

    assign run     = (state_q == ST_COUNTDOWN) || (state_q == ST_PLAY);
    assign in_play = (state_q == ST_PLAY);
    assign accept  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    beat_timer #(
        .BEAT_DIV(BEAT_DIV)
    ) u_beat_timer (
        .clk  (clk),
        .nrst (nrst),
        .run  (run),
        .clear(accept),
        .tick (tick)
    );

    // Per-lane scoring. A press on the tick cycle is credited before the
    // end-of-beat check, so a good press suppresses that lane's end miss.
    logic [LANES-1:0] note_here, good, bad, end_miss, lane_miss;

    assign note_here = {sh2_q[beat_q], sh1_q[beat_q]};
    assign good      = in_play ? (hit & note_here & ~cons_q) : '0;
    assign bad       = in_play ? (hit & ~good) : '0;
    assign end_miss  = (in_play && tick) ? (note_here & ~cons_q & ~good) : '0;
    assign lane_miss = bad | end_miss;

    logic [1:0] good_n, miss_inc;
    assign good_n   = {1'b0, good[0]} + {1'b0, good[1]};
    assign miss_inc = {1'b0, lane_miss[0]} + {1'b0, lane_miss[1]};

    logic bonus;

`ifdef GV_STREAK_EN
    logic [3:0] streak_q, streak_d;
    logic [4:0] streak_sum;

    assign bonus      = (streak_q >= 4'd4);
    assign streak_sum = {1'b0, streak_q} + {3'b000, good_n};

    always_comb begin
        streak_d = streak_q;
        if (accept || (miss_inc != 2'd0)) begin
            streak_d = '0;
        end else if (good_n != 2'd0) begin
            streak_d = (streak_sum > 5'd15) ? 4'hF : streak_sum[3:0];
        end
    end

    assign streak = streak_q;
`else
    assign bonus = 1'b0;
`endif

    // Sums are computed wide enough to hold the worst-case overflow so the
    // saturation compare never sees a wrapped value.
    logic [2:0]         score_add;
    logic [SCORE_W+2:0] score_sum;
    logic [6:0]         miss_sum;

    assign score_add = bonus ? {good_n, 1'b0} : {1'b0, good_n};
    assign score_sum = {3'b000, score_q} + {{SCORE_W{1'b0}}, score_add};
    assign miss_sum  = {1'b0, miss_q} + {5'b00000, miss_inc};

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        cd_d    = cd_q;
        sh1_d   = sh1_q;
        sh2_d   = sh2_q;
        cons_d  = cons_q;
        score_d = score_q;
        miss_d  = miss_q;

        if (in_play) begin
            score_d = (score_sum > {3'b000, {SCORE_W{1'b1}}}) ? '1 : score_sum[SCORE_W-1:0];
            miss_d  = (miss_sum > 7'd63) ? 6'd63 : miss_sum[5:0];
            cons_d  = tick ? '0 : (cons_q | good);
        end

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_COUNTDOWN;
                    sh1_d   = note1;
                    sh2_d   = note2;
                    beat_d  = '0;
                    cd_d    = '0;
                    cons_d  = '0;
                    score_d = '0;
                    miss_d  = '0;
                end
            end
            ST_COUNTDOWN: begin
                if (tick) begin
                    if (cd_q == CD_LAST) begin
                        state_d = ST_PLAY;
                        beat_d  = '0;
                    end else begin
                        cd_d = cd_q + CDW'(1);
                    end
                end
            end
            ST_PLAY: begin
                if (tick) begin
                    if (beat_q == 5'd31) begin
                        state_d = ST_DONE;
                    end else begin
                        beat_d = beat_q + 5'd1;
                    end
                end
            end
            default: ;
        endcase

        // Window and done are derived from next-state values so they land on
        // the same edge as beat_idx/state.
        win1_d = window_slice(sh1_d, beat_d, state_d == ST_PLAY);
        win2_d = window_slice(sh2_d, beat_d, state_d == ST_PLAY);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= ST_IDLE;
            beat_q   <= '0;
            cd_q     <= '0;
            sh1_q    <= '0;
            sh2_q    <= '0;
            cons_q   <= '0;
            score_q  <= '0;
            miss_q   <= '0;
            win1_q   <= '0;
            win2_q   <= '0;
            done_q   <= 1'b0;
`ifdef GV_STREAK_EN
            streak_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            cd_q     <= cd_d;
            sh1_q    <= sh1_d;
            sh2_q    <= sh2_d;
            cons_q   <= cons_d;
            score_q  <= score_d;
            miss_q   <= miss_d;
            win1_q   <= win1_d;
            win2_q   <= win2_d;
            done_q   <= done_d;
`ifdef GV_STREAK_EN
            streak_q <= streak_d;
`endif
        end
    end

    assign state    = state_q;
    assign beat_idx = beat_q;
    assign score    = score_q;
    assign miss_cnt = miss_q;
    assign window1  = win1_q;
    assign window2  = win2_q;
    assign done     = done_q;

endmodule

// File: tb/tb_note_player.sv
// -----------------------------------------------------------------------------
// tb_note_player
// Scoreboard bench for note_player: an independent cycle model pushes the
// expected outputs every clock; they are popped and compared on the falling
// edge. Directed checks cover latency, end-of-run totals and saturation.
// -----------------------------------------------------------------------------
module tb_note_player;

    localparam int unsigned BD   = 4;
    localparam int unsigned CDB  = 2;
    localparam int unsigned SW   = 6;
    localparam int          SMAX = (1 << SW) - 1;
`ifdef GV_STREAK_EN
    localparam bit STREAK = 1'b1;
`else
    localparam bit STREAK = 1'b0;
`endif

    logic        clk;
    logic        nrst;
    logic        start;
    logic [31:0] note1, note2;
    logic [1:0]  hit;
    logic [7:0]  window1, window2;
    logic [4:0]  beat_idx;
    logic [SW-1:0] score;
    logic [5:0]  miss_cnt;
    logic [1:0]  state;
    logic        done;
    logic [3:0]  dut_streak;

    note_player #(
        .BEAT_DIV       (BD),
        .COUNTDOWN_BEATS(CDB),
        .SCORE_W        (SW)
    ) dut (
        .clk     (clk),
        .nrst    (nrst),
        .start   (start),
        .note1   (note1),
        .note2   (note2),
        .hit     (hit),
        .window1 (window1),
        .window2 (window2),
        .beat_idx(beat_idx),
        .score   (score),
        .miss_cnt(miss_cnt),
        .state   (state),
        .done    (done)
`ifdef GV_STREAK_EN
        ,
        .streak  (dut_streak)
`endif
    );

`ifndef GV_STREAK_EN
    assign dut_streak = 4'd0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    int          m_state, m_cnt, m_cd, m_beat, m_score, m_miss, m_streak;
    logic [31:0] m_sh1, m_sh2;
    bit          m_cons [2];
    logic [63:0] exp_q [$];

    function automatic logic [63:0] model_outs();
        logic [7:0] w1, w2;
        w1 = '0;
        w2 = '0;
        if (m_state == 2) begin
            for (int k = 0; k < 8; k++) begin
                if (m_beat + k <= 31) begin
                    w1[k] = m_sh1[m_beat + k];
                    w2[k] = m_sh2[m_beat + k];
                end
            end
        end
        return {24'd0, 4'(m_streak), 2'(m_state), 5'(m_beat), w1, w2,
                SW'(m_score), 6'(m_miss), 1'(m_state == 3)};
    endfunction

    function automatic logic [63:0] dut_outs();
        return {24'd0, dut_streak, state, beat_idx, window1, window2, score, miss_cnt, done};
    endfunction

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_cd = 0; m_beat = 0;
        m_score = 0; m_miss = 0; m_streak = 0;
        m_sh1 = '0; m_sh2 = '0;
        m_cons[0] = 0; m_cons[1] = 0;
    endtask

    task automatic model_step();
        bit tick, bonus, n, g;
        int goods, misses;
        tick = (m_state == 1 || m_state == 2) && (m_cnt == BD - 1);
        if (m_state == 2) begin
            goods  = 0;
            misses = 0;
            bonus  = STREAK && (m_streak >= 4);
            for (int L = 0; L < 2; L++) begin
                n = (L == 0) ? m_sh1[m_beat] : m_sh2[m_beat];
                g = 0;
                if (hit[L]) begin
                    if (n && !m_cons[L]) begin g = 1; goods++; end
                    else misses++;
                end
                if (tick && n && !m_cons[L] && !g) misses++;
                if (tick) m_cons[L] = 0;
                else if (g) m_cons[L] = 1;
            end
            m_score += goods * (bonus ? 2 : 1);
            if (m_score > SMAX) m_score = SMAX;
            m_miss += misses;
            if (m_miss > 63) m_miss = 63;
            if (STREAK) begin
                if (misses > 0) m_streak = 0;
                else begin
                    m_streak += goods;
                    if (m_streak > 15) m_streak = 15;
                end
            end
        end
        if (start && (m_state == 0 || m_state == 3)) begin
            m_state = 1; m_cnt = 0; m_cd = 0; m_beat = 0;
            m_score = 0; m_miss = 0; m_streak = 0;
            m_sh1 = note1; m_sh2 = note2;
            m_cons[0] = 0; m_cons[1] = 0;
        end else begin
            if (m_state == 1 || m_state == 2) m_cnt = tick ? 0 : m_cnt + 1;
            if (m_state == 1 && tick) begin
                m_cd++;
                if (m_cd == CDB) begin m_state = 2; m_beat = 0; end
            end else if (m_state == 2 && tick) begin
                if (m_beat == 31) m_state = 3;
                else m_beat++;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!nrst) begin
                model_reset();
                exp_q.delete();
            end else begin
                model_step();
                exp_q.push_back(model_outs());
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) check("outs", dut_outs(), exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    function automatic logic [1:0] pick(input int mode);
        if (m_state != 2) return 2'b00;
        case (mode)
            1: return (m_cnt == 1) ? 2'b11 : 2'b00;
            2: begin
                if (m_beat != 0) return 2'b00;
                if (m_cnt == 0) return 2'b10;
                if (m_cnt == 1 || m_cnt == 2) return 2'b01;
                return 2'b00;
            end
            3: return (m_beat == 0 && m_cnt == BD - 1) ? 2'b01 : 2'b00;
            4: begin
                if (m_cnt != 1) return 2'b00;
                return (m_beat == 10) ? 2'b01 : 2'b11;
            end
            default: return 2'b00;
        endcase
    endfunction

    task automatic kick(input logic [31:0] n1, input logic [31:0] n2);
        @(negedge clk);
        note1 = n1;
        note2 = n2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        note1 = ~n1;
        note2 = ~n2;
    endtask

    task automatic play(input int mode, output int cyc);
        cyc = 0;
        while (m_state != 3 && cyc < 2000) begin
            hit   = pick(mode);
            start = (mode == 3 && m_state == 2 && m_beat == 5 && m_cnt == 0);
            @(negedge clk);
            cyc++;
            if (start) check("mid_start_state", 64'(state), 64'd2);
            start = 1'b0;
`ifdef GV_STREAK_EN
            if (mode == 4 && m_state == 2 && m_beat == 11 && m_cnt == 0)
                check("streak_clear", 64'(dut_streak), 64'd0);
`endif
        end
        hit = 2'b00;
        check("done_flag", 64'(done), 64'd1);
        check("done_state", 64'(state), 64'd3);
    endtask

    int cyc;

    initial begin
        nrst  = 1'b0;
        start = 1'b0;
        note1 = '0;
        note2 = '0;
        hit   = 2'b00;
        repeat (3) @(negedge clk);
        check("rst_state", 64'(state), 64'd0);
        check("rst_counts", {42'd0, score, miss_cnt, beat_idx, done}, 64'd0);
        check("rst_window", {48'd0, window1, window2}, 64'd0);
        nrst = 1'b1;

        // start latency and snapshot
        kick(32'h0000_0001, 32'h0);
        check("cd_entry", 64'(state), 64'd1);
        repeat (6) @(negedge clk);
        check("cd_hold", 64'(state), 64'd1);
        repeat (2) @(negedge clk);
        check("play_entry", 64'(state), 64'd2);
        check("play_beat0", 64'(beat_idx), 64'd0);
        check("play_win1", 64'(window1), 64'h01);
        check("play_win2", 64'(window2), 64'h00);
        play(0, cyc);
        check("t1_miss", 64'(miss_cnt), 64'd1);

        // perfect run; 64 hits exceed the 6-bit score range
        kick(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        play(1, cyc);
        check("run_len", 64'(cyc), 64'((CDB + 32) * BD));
        check("perfect_score", 64'(score), 64'(SMAX));
        check("perfect_miss", 64'(miss_cnt), 64'd0);

        // no presses
        kick(32'hAAAA_AAAA, 32'h5555_5555);
        play(0, cyc);
        check("idle_miss", 64'(miss_cnt), 64'd32);
        check("idle_score", 64'(score), 64'd0);

        // wrong lane and double press
        kick(32'h0000_0001, 32'h0);
        play(2, cyc);
        check("wrong_score", 64'(score), 64'd1);
        check("wrong_miss", 64'(miss_cnt), 64'd2);

        // hit on the tick cycle, plus ignored start mid-play
        kick(32'h0000_0001, 32'h0);
        play(3, cyc);
        check("tick_score", 64'(score), 64'd1);
        check("tick_miss", 64'(miss_cnt), 64'd0);

        // miss saturation: 64 end-of-beat misses
        kick(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        play(0, cyc);
        check("miss_sat", 64'(miss_cnt), 64'd63);

        // single forced miss in an otherwise perfect run
        kick(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        play(4, cyc);
        check("break_miss", 64'(miss_cnt), 64'd1);
        check("break_score", 64'(score), 64'(SMAX));

        // reset mid-play
        kick(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (20) @(negedge clk);
        #1 nrst = 1'b0;
        #1;
        check("midrst_state", 64'(state), 64'd0);
        check("midrst_counts", {42'd0, score, miss_cnt, beat_idx, done}, 64'd0);
        check("midrst_window", {48'd0, window1, window2}, 64'd0);
        check("midrst_streak", 64'(dut_streak), 64'd0);
        @(negedge clk);
        nrst = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_state", 64'(state), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/note_player.md
# note_player

Playback and scoring stage downstream of the song editor. On a start pulse it snapshots the two 32-step note lanes and steps through them one beat at a time after a countdown. It scores synchronized player hit pulses against the current beat and drives an 8-beat look-ahead window for the display driver.

## Interface
Parameters:
- BEAT_DIV, 100000: clk cycles per beat; minimum 2.
- COUNTDOWN_BEATS, 4: beats spent in COUNTDOWN before beat 0; minimum 1.
- SCORE_W, 8: width of score.

Ports:
- clk  in  1  system clock.
- nrst  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle start pulse, already edge-detected upstream.
- note1  in  32  lane 1 pattern from the editor; bit i=1 means a note at beat i.
- note2  in  32  lane 2 pattern from the editor.
- hit  in  2  single-cycle synchronized player presses; bit0 is lane 1, bit1 is lane 2.
- window1  out  8  lane 1 look-ahead; bit0 is the current beat.
- window2  out  8  lane 2 look-ahead.
- beat_idx  out  5  current beat, 0..31.
- score  out  SCORE_W  hit count, saturating.
- miss_cnt  out  6  miss count, saturating at 63.
- state  out  2  FSM state encoding.
- done  out  1  high while the FSM is in DONE.
- streak  out  4  consecutive-hit count; present only when GV_STREAK_EN is defined.

## Operation
FSM states: IDLE=0, COUNTDOWN=1, PLAY=2, DONE=3.

Transitions:
- IDLE→COUNTDOWN on start.
- COUNTDOWN→PLAY after COUNTDOWN_BEATS beat ticks.
- PLAY→DONE on the beat tick that ends beat 31.
- DONE→COUNTDOWN on start.

Start behaviour:
- On an accepted start: copy note1/note2 into shadow registers, clear score, miss_cnt, streak, beat_idx, consumed flags and the beat counter.
- start in COUNTDOWN or PLAY is ignored.
- Editor changes after the snapshot do not affect playback.

Beat ticks:
- The beat counter runs in COUNTDOWN and PLAY only.
- A tick occurs on the cycle the counter equals BEAT_DIV-1; the counter then wraps to 0.

Scoring per lane L, in PLAY:
- Each lane has a consumed flag for the current beat.
- hit[L] with shadowL[beat_idx]=1 and the flag clear: score+1, set the flag.
- hit[L] with no note present, or with the flag already set: miss_cnt+1.
- On a beat tick, a note present but not consumed: miss_cnt+1.
- The flags clear after each beat tick.

Scoring outside PLAY:
- hit is ignored in IDLE, COUNTDOWN and DONE.

Simultaneous events:
- The two lanes are evaluated independently in the same cycle, so miss_cnt can increase by 2 in one cycle.
- A hit on a beat-tick cycle is credited to the ending beat, and that beat's end-of-beat miss check sees it as consumed.
- A lane's bad press and its own end-of-beat miss cannot coincide; different lanes can.

Arithmetic:
- score saturates at 2^SCORE_W-1; miss_cnt saturates at 63. No wrap in either.

Look-ahead window:
- windowL[k] = shadowL[beat_idx+k] for beat_idx+k ≤ 31, else 0.
- Forced to 0 in IDLE, COUNTDOWN and DONE.

## Timing
Reset values:
- state=IDLE, beat_idx=0, score=0, miss_cnt=0, done=0, window1=window2=0, streak=0.
- Shadow registers and beat counter are 0.

Latency:
- All outputs are registered.
- start sampled at edge n gives state=COUNTDOWN after edge n.
- Beat 0 begins the cycle after the last countdown tick: state=PLAY, beat_idx=0.
- beat_idx, window and done update on the edge following the tick.
- Score and miss effects appear one cycle after the qualifying input or tick.

Beat length:
- Each beat lasts exactly BEAT_DIV cycles.
- One full run is (COUNTDOWN_BEATS+32)·BEAT_DIV cycles from start to done.

Reset mid-operation: an nrst assertion at any point returns to reset values immediately; the snapshot is lost.

## Configuration
GV_STREAK_EN defined:
- A 4-bit saturating streak counter increments on each scored hit.
- Any miss event clears it; clearing takes priority over incrementing in the same cycle.
- A hit scored while streak ≥ 4 (value before the increment) adds 2 to score, still saturating.
- The streak port exists.

GV_STREAK_EN undefined: no streak logic and no streak port; every hit adds 1.

## Structure
Shared package gv_pkg holds:
- The FSM enum type.
- Constants SONG_LEN=32, LANES=2, WINDOW=8.

One sub-module, beat_timer:
- Parameterized by BEAT_DIV.
- Inputs: clk, nrst, run, clear. Output: tick.
- note_player instantiates it once.

## Test plan
- **Reset:** reset, BEAT_DIV=4, COUNTDOWN_BEATS=2, note1=32'h0000_0001, note2=0. Pulse start → PLAY, beat_idx=0 and window1=8'h01 exactly 8 cycles after the start edge.
- **Perfect run:** note1=note2=32'hFFFF_FFFF; pulse hit=2'b11 once per beat → done, score=64 (SCORE_W=8), miss_cnt=0.
- **No presses:** note1=32'hAAAA_AAAA, note2=32'h5555_5555, no hits → miss_cnt=32, score=0.
- **Wrong lane and double press:** note1 bit0=1, note2=0; at beat 0 press hit=2'b10, then hit=2'b01 twice → score=1, miss_cnt=2.
- **Beat-tick coincidence:** press hit[0] on the tick cycle ending a beat whose note1 bit is 1 → score+1, no miss. Pulse start mid-PLAY → no state change.
- **Saturation (GV_STREAK_EN and SCORE_W=5):** all-ones lanes with perfect hits → score saturates at 31. A single forced miss clears streak to 0.
